mul_seq: RTL and testbench

//  Sequential signed multiplier for the 3-bit ALU; the inverse of the remainder/divide path.

---
 rtl/alu_pkg.sv | 15 +
 rtl/booth_step.sv | 28 ++
 rtl/mul_seq.sv | 81 ++++++++
 tb/tb_mul_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, FSM state and operand/product types
package alu_pkg;

    localparam int ALU_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic signed [ALU_WIDTH-1:0]   operand_t;
    typedef logic signed [2*ALU_WIDTH-1:0] product_t;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth iteration: conditional +/-A on the upper part, then arithmetic shift
module booth_step #(
    parameter int WIDTH = 3
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] a,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0] hi;
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] sum;

    // One guard bit on the adder so that subtracting the most negative A cannot wrap;
    // the shift then drops exactly that extra bit back into a 2*WIDTH+1 accumulator.
    always_comb begin
        hi    = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        ext_a = {a[WIDTH-1], a};
        sum   = hi;
        case (acc[1:0])
            2'b01:   sum = hi + ext_a;
            2'b10:   sum = hi - ext_a;
            default: sum = hi;
        endcase
        acc_next = {sum, acc[WIDTH:1]};
    end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential signed Booth multiplier with valid/ready on both sides
module mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_next;
    logic               last_step;

    booth_step #(.WIDTH(WIDTH)) u_booth_step (
        .acc      (acc),
        .a        (a_reg),
        .acc_next (acc_next)
    );

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_reg <= '0;
            acc   <= '0;
            P     <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= A;
                        acc   <= {{WIDTH{1'b0}}, B, 1'b0};
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    // Product is captured from the final step so DONE presents it directly.
                    if (last_step) begin
                        P    <= acc_next[2*WIDTH:1];
                        zero <= ~|acc_next[2*WIDTH:1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq: directed vectors, stalls, reset abort, full sweep
module tb_mul_seq;
    import alu_pkg::*;

    localparam int W = ALU_WIDTH;

    typedef struct packed {
        logic [2*W-1:0] p;
        logic           z;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] P;
    logic           zero;

    exp_t           sb_q[$];
    exp_t           mon_e;
    int             n_checks = 0;
    int             n_fail = 0;
    int             n_in = 0;
    int             n_out = 0;
    int             n_aborted = 0;
    logic           rand_stall = 1'b0;
    logic           ready_level = 1'b1;
    logic [2*W-1:0] hold_p;

    mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got P=0x%0h with empty scoreboard, expected none", P);
            end else begin
                mon_e = sb_q.pop_front();
                check("P", 32'(P), 32'(mon_e.p));
                check("zero", 32'(zero), 32'(mon_e.z));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_stall ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] p_exp, input logic z_exp);
        int   t;
        logic done;
        t    = 0;
        done = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                sb_q.push_back({p_exp, z_exp});
                n_in++;
            end else if (++t > 100) begin
                done = 1'b1;
                check("send_timeout", 32'(in_ready), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_latency(input string name, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        check(name, 32'(lat), 32'(exp_lat));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || !in_ready) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", 32'(t < 400), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_P", 32'(P), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 3 * -3 = -9
        send(3'b011, 3'b101, 6'b110111, 1'b0);
        check_latency("latency_t1", 3);
        drain();

        // -4 * -4 = +16 and -4 * 3 = -12
        send(3'b100, 3'b100, 6'b010000, 1'b0);
        send(3'b100, 3'b011, 6'b110100, 1'b0);
        drain();

        // zero multiplicand still takes the full iteration count
        send(3'b000, 3'b110, 6'b000000, 1'b1);
        check_latency("latency_zero", 3);
        drain();

        // backpressure: -1 * 3 = -3 held while a new in_valid is ignored
        ready_level = 1'b0;
        repeat (2) @(posedge clk);
        send(3'b111, 3'b011, 6'b111101, 1'b0);
        check_latency("latency_stall", 3);
        hold_p = P;
        check("stall_P_value", 32'(hold_p), 32'h3d);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A = 3'b010;
        B = 3'b010;
        repeat (10) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_P_stable", 32'(P), 32'(hold_p));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        ready_level = 1'b1;
        drain();
        send(3'b001, 3'b110, 6'b111110, 1'b0);
        drain();

        // async reset during CALC discards the operation
        send(3'b011, 3'b011, 6'b001001, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        sb_q.delete();
        n_aborted++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_output", 32'(out_valid), 32'd0);
        end
        send(3'b010, 3'b010, 6'b000100, 1'b0);
        drain();

        // full sweep against a signed reference with random consumer stalls
        rand_stall = 1'b1;
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                operand_t sa;
                operand_t sb;
                product_t pr;
                int       prod;
                sa   = operand_t'(ia);
                sb   = operand_t'(ib);
                prod = int'(sa) * int'(sb);
                pr   = product_t'(prod);
                send(3'(ia), 3'(ib), pr, pr == '0);
            end
        end
        drain();
        rand_stall = 1'b0;
        @(posedge clk);

        check("handshake_balance", 32'(n_in - n_aborted), 32'(n_out));
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
